// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step clock controller.
//   btn_state_t    - debounce FSM state encoding (2 bits)
//   DEF_*          - default parameter values
//   ctr_width()    - width of an up-counter that must reach the largest of
//                    three terminal counts
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_RUN_DIV         = 25000000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
    localparam int unsigned DEF_CNT_W           = 16;

    // clog2 of the largest argument; the +1 lets the counter hold the
    // terminal value itself, not just values below it.
    function automatic int unsigned ctr_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM and a
// registered one-cycle pulse per accepted press.
// Ports:
//   clk      - system clock
//   srst     - synchronous active-high reset
//   btn_raw  - raw asynchronous button, active high
//   held     - FSM currently in S_HELD (button accepted and still down)
//   press    - one-cycle pulse, first cycle of S_HELD after an accepted press
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CTR_W           = 17
) (
    input  logic clk,
    input  logic srst,
    input  logic btn_raw,
    output logic held,
    output logic press
);

    localparam logic [CTR_W-1:0] CNT_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             btn_s;
    btn_state_t       state_reg, state_next;
    logic [CTR_W-1:0] cnt_reg, cnt_next;
    logic             press_reg, press_next;

    assign btn_s = sync_reg[1];

    // State register, counter, synchronizer and press pulse register
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg  <= 2'b00;
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn_raw};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            press_reg <= press_next;
        end
    end

    // Next-state logic. cnt holds the number of consecutive samples seen
    // at the new level; both edges need DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (btn_s) begin
                    state_next = S_PRESS;
                    cnt_next   = CNT_ONE;
                end
            end
            S_PRESS: begin
                if (!btn_s)                 state_next = S_IDLE;
                else if (cnt_reg == CNT_LAST) state_next = S_HELD;
                else                        cnt_next   = cnt_reg + 1'b1;
            end
            S_HELD: begin
                if (!btn_s) begin
                    state_next = S_RELEASE;
                    cnt_next   = CNT_ONE;
                end
            end
            S_RELEASE: begin
                // A bounce back high returns to S_HELD without a new press.
                if (btn_s)                  state_next = S_HELD;
                else if (cnt_reg == CNT_LAST) state_next = S_IDLE;
                else                        cnt_next   = cnt_reg + 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: the press is recognised on the PRESS->HELD transition.
    always_comb begin
        press_next = (state_reg == S_PRESS) && btn_s && (cnt_reg == CNT_LAST);
    end

    assign held  = (state_reg == S_HELD);
    assign press = press_reg;

endmodule

// File: rtl/step_clock_ctrl.sv
// Step clock controller for the single-cycle MIPS core. Produces o_Step,
// a one-cycle advance enable, from either a debounced push-button (one step
// per press) or a free-running divider in run mode. A halt request stops
// all stepping until reset. Issued steps are counted with saturation.
// Optional feature macro: STEP_REPEAT_EN - auto-repeat while the button is
// held (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
// Ports:
//   i_Clk, i_Rst   - clock, synchronous active-high reset
//   i_Btn_step     - raw step button (asynchronous)
//   i_Run          - raw run switch (asynchronous), 1 = run
//   i_Halt         - halt request from the core (synchronous)
//   o_Step         - one-cycle advance enable
//   o_Running      - run mode active and not halted
//   o_Halted       - sticky halt flag
//   o_Step_count   - saturating count of issued steps
module step_clock_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Btn_step,
    input  logic             i_Run,
    input  logic             i_Halt,
    output logic             o_Step,
    output logic             o_Running,
    output logic             o_Halted,
    output logic [CNT_W-1:0] o_Step_count
);

    localparam int unsigned REPEAT_MAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CTR_W = ctr_width(DEBOUNCE_CYCLES, RUN_DIV, REPEAT_MAX);
    localparam logic [CTR_W-1:0] DIV_LAST = CTR_W'(RUN_DIV - 1);

    logic             btn_held;
    logic             btn_press;
    logic [1:0]       run_sync_reg;
    logic             run_s;
    logic [CTR_W-1:0] div_reg, div_next;
    logic             run_req;
    logic             auto_req;
    logic             step_reg, step_next;
    logic             running_reg, running_next;
    logic             halted_reg, halted_next;
    logic [CNT_W-1:0] count_reg, count_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CTR_W           (CTR_W)
    ) u_btn_debounce (
        .clk     (i_Clk),
        .srst    (i_Rst),
        .btn_raw (i_Btn_step),
        .held    (btn_held),
        .press   (btn_press)
    );

    assign run_s = run_sync_reg[1];

    // Run divider: free-runs only while run is selected and not halted;
    // parked at 0 when run is off so the first step is a full period later.
    always_comb begin
        div_next = div_reg;
        if (!run_s)
            div_next = '0;
        else if (!halted_reg)
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    end

    assign run_req = run_s && !halted_reg && (div_reg == DIV_LAST);

`ifdef STEP_REPEAT_EN
    localparam logic [CTR_W-1:0] HOLD_DELAY  = CTR_W'(REPEAT_DELAY);
    localparam logic [CTR_W-1:0] HOLD_PERIOD = CTR_W'(REPEAT_PERIOD);

    logic             in_hold;
    logic [CTR_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             repeating_reg, repeating_next;
    logic [CTR_W-1:0] hold_limit;

    // hold_cnt is 0 on the first S_HELD cycle and restarts on every entry,
    // so a release bounce also restarts the repeat delay.
    assign in_hold    = btn_held && !run_s;
    assign hold_limit = repeating_reg ? HOLD_PERIOD : HOLD_DELAY;
    assign auto_req   = in_hold && (hold_cnt_reg == hold_limit);

    always_comb begin
        hold_cnt_next  = hold_cnt_reg;
        repeating_next = repeating_reg;
        if (!in_hold) begin
            hold_cnt_next  = '0;
            repeating_next = 1'b0;
        end else if (auto_req) begin
            hold_cnt_next  = CTR_W'(1);
            repeating_next = 1'b1;
        end else begin
            hold_cnt_next  = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hold_cnt_reg  <= '0;
            repeating_reg <= 1'b0;
        end else begin
            hold_cnt_reg  <= hold_cnt_next;
            repeating_reg <= repeating_next;
        end
    end
`else
    logic unused_held;
    assign unused_held = btn_held;
    assign auto_req    = 1'b0;
`endif

    // Manual and auto requests are dropped in run mode; since the run
    // divider is then the only source, at most one request exists per cycle.
    // A halt seen this cycle suppresses any request landing with it.
    always_comb begin
        step_next    = (run_req || (!run_s && (btn_press || auto_req)))
                       && !i_Halt && !halted_reg;
        halted_next  = halted_reg || i_Halt;
        running_next = run_s && !halted_next;
        count_next   = (step_reg && (count_reg != '1)) ? count_reg + 1'b1 : count_reg;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            run_sync_reg <= 2'b00;
            div_reg      <= '0;
            step_reg     <= 1'b0;
            running_reg  <= 1'b0;
            halted_reg   <= 1'b0;
            count_reg    <= '0;
        end else begin
            run_sync_reg <= {run_sync_reg[0], i_Run};
            div_reg      <= div_next;
            step_reg     <= step_next;
            running_reg  <= running_next;
            halted_reg   <= halted_next;
            count_reg    <= count_next;
        end
    end

    assign o_Step       = step_reg;
    assign o_Running    = running_reg;
    assign o_Halted     = halted_reg;
    assign o_Step_count = count_reg;

endmodule
